data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache for the Memory stage of the pipelined CPU. It sits between the Memory-stage pipeline register and a word-wide backing memory. Hits complete combinationally in the same cycle. Misses stall the whole pipeline while a finite state machine writes back a dirty victim line and then refills the line in a 4-beat burst.

## Interface
- `DATA_WIDTH`, default 32: word width; fixed at 32 in use.
- `SETS`, default 64: number of lines; must be a power of 2. Line size is fixed at 4 words (16 bytes).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; synchronous and active-high.
- `ALUResultM` in 32: byte address of the access.
- `WriteDataM` in 32: store data, right-aligned.
- `MemWriteM` in 1: store request.
- `MemReadM` in 1: load request. Never asserted together with `MemWriteM`.
- `AddressingControlM` in 3: funct3. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `ReadDataM` out 32: extended load data. Valid when `StallMem`=0 and `MemReadM`=1.
- `StallMem` out 1: freeze all pipeline registers, including Writeback.
- `mem_req` out 1: beat request to backing memory.
- `mem_we` out 1: 1 = write beat, 0 = read beat.
- `mem_addr` out 32: word-aligned byte address of the current beat.
- `mem_wdata` out 32: write beat data.
- `mem_ready` in 1: current beat accepted. On read beats, `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read beat data.

## Operation
- **Address split:**
  - Tag = `addr[31:4+log2(SETS)]`.
  - Index = `addr[3+log2(SETS):4]`.
  - Word = `addr[3:2]`.
  - Byte = `addr[1:0]`.
- **Per-line state:** valid bit, dirty bit, tag, 4 data words. Reset clears all valid and dirty bits. Tag and data arrays are not reset.
- **Hit:** access active (`MemReadM` or `MemWriteM`) and line valid and tag equal.
- **States:** IDLE, WB, REFILL. A 2-bit beat counter is shared by WB and REFILL.
- **IDLE:**
  - No access: `StallMem`=0.
  - Hit: `StallMem`=0. A store updates the selected bytes at the clock edge and sets dirty.
  - Miss: `StallMem`=1. Next state is WB if the victim is valid and dirty, else REFILL. The beat counter is cleared to 0.
- **WB:**
  - `mem_req`=1, `mem_we`=1.
  - `mem_addr` = {victim tag, index, beat, 2'b00}; `mem_wdata` = victim word[beat].
  - Each `mem_ready` increments the beat counter. After beat 3 is accepted: go to REFILL, clear the beat counter, clear dirty.
- **REFILL:**
  - `mem_req`=1, `mem_we`=0.
  - `mem_addr` = {request tag, index, beat, 2'b00}.
  - Each `mem_ready` writes `mem_rdata` into word[beat].
  - After beat 3: set valid and tag, go to IDLE. The access re-evaluates as a hit the next cycle.
- `StallMem`=1 in WB and REFILL.
- `mem_req`=0 in IDLE.
- `mem_we` and `mem_wdata` are don't-care when `mem_req`=0.
- **Loads:**
  - LB/LBU select byte `addr[1:0]`; LH/LHU select halfword `addr[1]`, with `addr[0]` ignored; LW ignores `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Stores:** SB writes the byte at `addr[1:0]` from `WriteDataM[7:0]`. SH writes the halfword at `addr[1]` from `WriteDataM[15:0]`. SW writes the whole word.
- Misaligned accesses are not trapped; the ignored low bits make their behaviour defined.
- Address and request inputs must stay stable while `StallMem`=1. This is guaranteed by the pipeline freeze.

## Timing
- **Reset values:** state IDLE, beat counter 0, `mem_req`=0, `StallMem`=0 when no access. After reset the next access misses.
- **Hit latency:** 0 cycles, combinational. Store data is visible to a load in the next cycle.
- **Clean miss, zero-wait memory:** 1 detect cycle + 4 REFILL cycles = 5 stall cycles. The hit completes in cycle 6.
- **Dirty miss, zero-wait memory:** 1 + 4 + 4 = 9 stall cycles.
- **Memory wait states:** each cycle with `mem_req`=1 and `mem_ready`=0 adds one stall cycle and holds address, data and beat.
- **Reset mid-burst:** state goes to IDLE and `mem_req`=0 on the next edge. The partial line stays invalid, because valid bits are cleared.
- A store that misses completes as a store hit in the cycle after REFILL.

## Test plan
- **Cold load miss:** reset, preload backing memory 0x100..0x10C = 0x11, 0x22, 0x33, 0x44; LW 0x104 with zero-wait memory.
  - Expect `StallMem`=1 for 5 cycles.
  - Expect `mem_addr` = 0x100, 0x104, 0x108, 0x10C.
  - Expect `ReadDataM`=0x22 in cycle 6.
  - A following LW 0x10C returns 0x44 with no stall.
- **Sub-word store/load:** after the cold-miss scenario, SB 0x105 with data 0xFF.
  - LW 0x104 returns 0x0000FF22.
  - LB 0x105 returns 0xFFFFFFFF.
  - LBU 0x105 returns 0x000000FF.
  - SH 0x106 with 0x8001, then LH 0x106 returns 0xFFFF8001 and LHU 0x106 returns 0x00008001.
- **Dirty eviction (SETS=64):** after the sub-word scenario, LW 0x500, which maps to the same index.
  - Expect 4 write beats at 0x100..0x10C carrying 0x11, 0x8001FF22, 0x33, 0x44.
  - Then 4 read beats at 0x500..0x50C.
  - 9 stall cycles in total.
- **Clean eviction:** LW 0x100 again after the dirty-eviction scenario. Expect read beats only, 5 stall cycles, and `ReadDataM`=0x11.
- **Wait states:** `mem_ready` low for 2 cycles before each beat of a clean refill. Expect 13 stall cycles with `mem_addr` held stable during the waits.
- **Reset mid-refill:** `rst` asserted during REFILL beat 2.
  - Expect `mem_req`=0 on the next cycle.
  - A subsequent LW to the same line misses and refills the full 4 beats again.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the Memory stage.
// Hits are combinational; misses stall the pipeline while the line is
// written back (if dirty) and refilled in a 4-beat word burst.
module data_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic                  MemWriteM,
   input  logic                  MemReadM,
   input  logic [2:0]            AddressingControlM,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  StallMem,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 32 - 4 - IDX_W;

   typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

   state_t                 state_q;
   logic [1:0]             beat_q;
   logic [SETS-1:0]        valid_q;
   logic [SETS-1:0]        dirty_q;
   logic [TAG_W-1:0]       tag_q  [SETS];
   logic [DATA_WIDTH-1:0]  data_q [SETS][4];

   logic [TAG_W-1:0]       req_tag;
   logic [IDX_W-1:0]       idx;
   logic [1:0]             word_sel;
   logic [1:0]             byte_off;
   logic                   access;
   logic                   hit;
   logic                   store_hit;
   logic                   last_beat;

   assign req_tag  = ALUResultM[31:4+IDX_W];
   assign idx      = ALUResultM[3+IDX_W:4];
   assign word_sel = ALUResultM[3:2];
   assign byte_off = ALUResultM[1:0];

   assign access    = MemReadM | MemWriteM;
   assign hit       = access && valid_q[idx] && (tag_q[idx] == req_tag);
   assign store_hit = (state_q == IDLE) && MemWriteM && hit;
   assign last_beat = mem_ready && (beat_q == 2'd3);

   // Select and extend the addressed byte/halfword/word for a load.
   function automatic logic [DATA_WIDTH-1:0] load_ext(
      input logic [DATA_WIDTH-1:0] w,
      input logic [1:0]            off,
      input logic [2:0]            f3
   );
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  load_ext = {{(DATA_WIDTH-8){b[7]}}, b};
         3'b001:  load_ext = {{(DATA_WIDTH-16){h[15]}}, h};
         3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, b};
         3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, h};
         default: load_ext = w;
      endcase
   endfunction

   // Merge right-aligned store data into the old word at the addressed lanes.
   function automatic logic [DATA_WIDTH-1:0] store_merge(
      input logic [DATA_WIDTH-1:0] old,
      input logic [DATA_WIDTH-1:0] wd,
      input logic [1:0]            off,
      input logic [2:0]            f3
   );
      logic [DATA_WIDTH-1:0] m;
      m = old;
      case (f3[1:0])
         2'b00: begin
            case (off)
               2'd0:    m[7:0]   = wd[7:0];
               2'd1:    m[15:8]  = wd[7:0];
               2'd2:    m[23:16] = wd[7:0];
               default: m[31:24] = wd[7:0];
            endcase
         end
         2'b01: begin
            if (off[1]) m[31:16] = wd[15:0];
            else        m[15:0]  = wd[15:0];
         end
         default: m = wd;
      endcase
      store_merge = m;
   endfunction

   assign StallMem  = (state_q != IDLE) || (access && !hit);
   assign mem_req   = (state_q != IDLE);
   assign mem_we    = (state_q == WB);
   assign mem_addr  = (state_q == WB) ? {tag_q[idx], idx, beat_q, 2'b00}
                                      : {req_tag, idx, beat_q, 2'b00};
   assign mem_wdata = data_q[idx][beat_q];
   assign ReadDataM = load_ext(data_q[idx][word_sel], byte_off, AddressingControlM);

   // Miss-handling FSM plus the per-line valid/dirty bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= 2'd0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (access && !hit) begin
                  beat_q  <= 2'd0;
                  state_q <= (valid_q[idx] && dirty_q[idx]) ? WB : REFILL;
               end else if (store_hit) begin
                  dirty_q[idx] <= 1'b1;
               end
            end
            WB: begin
               if (mem_ready) begin
                  beat_q <= beat_q + 2'd1;
                  if (last_beat) begin
                     state_q      <= REFILL;
                     dirty_q[idx] <= 1'b0;
                  end
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  beat_q <= beat_q + 2'd1;
                  if (last_beat) begin
                     state_q      <= IDLE;
                     valid_q[idx] <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag and data arrays: store hits and refill beats; never reset.
   always_ff @(posedge clk) begin
      if (store_hit) begin
         data_q[idx][word_sel] <= store_merge(data_q[idx][word_sel], WriteDataM,
                                              byte_off, AddressingControlM);
      end else if ((state_q == REFILL) && mem_ready) begin
         data_q[idx][beat_q] <= mem_rdata;
         if (beat_q == 2'd3) tag_q[idx] <= req_tag;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: the bench plays the backing memory and
// holds a flat architectural memory plus a per-set residency model.
module tb_data_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic        MemWriteM;
   logic        MemReadM;
   logic [2:0]  AddressingControlM;
   logic [31:0] ReadDataM;
   logic        StallMem;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] gold    [4096];
   logic [31:0] backing [4096];
   bit          mv [64];
   bit          md [64];
   logic [21:0] mt [64];

   typedef struct {
      bit          we;
      logic [31:0] a;
   } beat_t;

   data_cache #(.DATA_WIDTH(32), .SETS(64)) dut (
      .clk               (clk),
      .rst               (rst),
      .ALUResultM        (ALUResultM),
      .WriteDataM        (WriteDataM),
      .MemWriteM         (MemWriteM),
      .MemReadM          (MemReadM),
      .AddressingControlM(AddressingControlM),
      .ReadDataM         (ReadDataM),
      .StallMem          (StallMem),
      .mem_req           (mem_req),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_ready         (mem_ready),
      .mem_rdata         (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural load result from a word of flat memory.
   function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [31:0] a,
                                            input logic [2:0] f3);
      logic [31:0] vb, vh;
      vb = w >> (8 * a[1:0]);
      vh = w >> (16 * a[1]);
      case (f3)
         3'b000:  return {{24{vb[7]}}, vb[7:0]};
         3'b001:  return {{16{vh[15]}}, vh[15:0]};
         3'b100:  return vb & 32'h0000_00FF;
         3'b101:  return vh & 32'h0000_FFFF;
         default: return w;
      endcase
   endfunction

   // Architectural store into flat memory.
   task automatic st_model(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
      logic [31:0] mask;
      int          sh;
      case (f3[1:0])
         2'b00:   begin sh = 8 * int'(a[1:0]); mask = 32'h0000_00FF << sh; end
         2'b01:   begin sh = 16 * int'(a[1]);  mask = 32'h0000_FFFF << sh; end
         default: begin sh = 0;                mask = 32'hFFFF_FFFF;       end
      endcase
      gold[a[13:2]] = (gold[a[13:2]] & ~mask) | ((wd << sh) & mask);
   endtask

   // One load/store from issue to completion, answering memory beats with
   // wmin..wmax wait cycles each. lit_stall < 0 disables the stall literal.
   task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int wmin, input int wmax,
                         input int lit_stall, input bit lit_rd_en, input logic [31:0] lit_rd);
      beat_t       q[$];
      beat_t       bt;
      int          idx;
      int          w;
      int          stalls;
      logic [21:0] tg;
      logic [31:0] ba;
      bit          bwe;
      idx = int'(addr[9:4]);
      tg  = addr[31:10];
      if (!(mv[idx] && mt[idx] == tg)) begin
         if (mv[idx] && md[idx]) begin
            for (int b = 0; b < 4; b++) begin
               bt.we = 1'b1;
               bt.a  = {mt[idx], addr[9:4], 2'(b), 2'b00};
               q.push_back(bt);
            end
         end
         for (int b = 0; b < 4; b++) begin
            bt.we = 1'b0;
            bt.a  = {addr[31:4], 2'(b), 2'b00};
            q.push_back(bt);
         end
         mv[idx] = 1'b1;
         mt[idx] = tg;
         md[idx] = 1'b0;
      end
      if (st) md[idx] = 1'b1;
      stalls = 0;
      @(negedge clk);
      ALUResultM         = addr;
      WriteDataM         = wd;
      MemWriteM          = st;
      MemReadM           = !st;
      AddressingControlM = f3;
      mem_ready          = 1'b0;
      mem_rdata          = 32'h0;
      if (q.size() != 0) begin
         #1;
         check("detect_stall", 32'(StallMem), 32'd1);
         check("detect_req", 32'(mem_req), 32'd0);
         stalls++;
         foreach (q[i]) begin
            ba  = q[i].a;
            bwe = q[i].we;
            w   = int'($urandom_range(wmax, wmin));
            for (int c = 0; c <= w; c++) begin
               @(negedge clk);
               mem_ready = (c == w);
               mem_rdata = bwe ? 32'h0 : backing[ba[13:2]];
               #1;
               check("beat_stall", 32'(StallMem), 32'd1);
               check("beat_req", 32'(mem_req), 32'd1);
               check("beat_we", 32'(mem_we), 32'(bwe));
               check("beat_addr", mem_addr, ba);
               if (bwe) begin
                  check("beat_wdata", mem_wdata, gold[ba[13:2]]);
                  if (c == w) backing[ba[13:2]] = mem_wdata;
               end
               stalls++;
            end
         end
         @(negedge clk);
         mem_ready = 1'b0;
      end
      #1;
      check("done_stall", 32'(StallMem), 32'd0);
      check("idle_req", 32'(mem_req), 32'd0);
      if (!st) begin
         check("load_data", ReadDataM, ld_model(gold[addr[13:2]], addr, f3));
         if (lit_rd_en) check("load_lit", ReadDataM, lit_rd);
      end else begin
         st_model(addr, wd, f3);
      end
      if (lit_stall >= 0) check("stall_lit", 32'(stalls), 32'(lit_stall));
   endtask

   initial begin
      logic [2:0]  lf3 [5];
      logic [31:0] ra;
      bit          rst_st;
      lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;

      rst = 1'b1;
      ALUResultM = 32'h0; WriteDataM = 32'h0; MemWriteM = 1'b0; MemReadM = 1'b0;
      AddressingControlM = 3'b010; mem_ready = 1'b0; mem_rdata = 32'h0;
      for (int i = 0; i < 4096; i++) backing[i] = $urandom;
      backing[12'h040] = 32'h11; backing[12'h041] = 32'h22;
      backing[12'h042] = 32'h33; backing[12'h043] = 32'h44;
      for (int i = 0; i < 4096; i++) gold[i] = backing[i];
      for (int i = 0; i < 64; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0; end

      repeat (2) @(negedge clk);
      #1;
      check("reset_stall", 32'(StallMem), 32'd0);
      check("reset_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // cold miss, then hits and sub-word accesses on the same line
      access(1'b0, 3'b010, 32'h104, 32'h0, 0, 0, 5, 1'b1, 32'h22);
      access(1'b0, 3'b010, 32'h10C, 32'h0, 0, 0, 0, 1'b1, 32'h44);
      access(1'b1, 3'b000, 32'h105, 32'hFF, 0, 0, 0, 1'b0, 32'h0);
      access(1'b0, 3'b010, 32'h104, 32'h0, 0, 0, 0, 1'b1, 32'h0000FF22);
      access(1'b0, 3'b000, 32'h105, 32'h0, 0, 0, 0, 1'b1, 32'hFFFFFFFF);
      access(1'b0, 3'b100, 32'h105, 32'h0, 0, 0, 0, 1'b1, 32'h000000FF);
      access(1'b1, 3'b001, 32'h106, 32'h8001, 0, 0, 0, 1'b0, 32'h0);
      access(1'b0, 3'b001, 32'h106, 32'h0, 0, 0, 0, 1'b1, 32'hFFFF8001);
      access(1'b0, 3'b101, 32'h106, 32'h0, 0, 0, 0, 1'b1, 32'h00008001);

      // dirty eviction, clean eviction, wait states
      access(1'b0, 3'b010, 32'h500, 32'h0, 0, 0, 9, 1'b0, 32'h0);
      check("wb_word1_lit", backing[12'h041], 32'h8001FF22);
      check("wb_word0_lit", backing[12'h040], 32'h11);
      access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 5, 1'b1, 32'h11);
      access(1'b0, 3'b010, 32'h900, 32'h0, 2, 2, 13, 1'b0, 32'h0);

      // reset during refill beat 2
      @(negedge clk);
      ALUResultM = 32'h800; MemReadM = 1'b1; MemWriteM = 1'b0; AddressingControlM = 3'b010;
      mem_ready = 1'b0;
      #1;
      check("rst_detect", 32'(StallMem), 32'd1);
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         mem_ready = 1'b1;
         mem_rdata = backing[12'h200 + 12'(b)];
         #1;
         check("rst_beat_addr", mem_addr, 32'h800 + 32'(4 * b));
      end
      @(negedge clk);
      mem_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_beat2_addr", mem_addr, 32'h808);
      check("rst_beat2_req", 32'(mem_req), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      MemReadM = 1'b0;
      #1;
      check("rst_req_low", 32'(mem_req), 32'd0);
      check("rst_stall_low", 32'(StallMem), 32'd0);
      for (int i = 0; i < 64; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
      for (int i = 0; i < 4096; i++) gold[i] = backing[i];
      access(1'b0, 3'b010, 32'h800, 32'h0, 0, 0, 5, 1'b0, 32'h0);

      // randomized traffic with random wait states
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(3, 0) == 0) ra = $urandom_range(16383, 0);
         else                           ra = $urandom_range(3071, 0);
         rst_st = ($urandom_range(2, 0) == 0);
         if (rst_st)
            access(1'b1, 3'($urandom_range(2, 0)), ra, $urandom, 0, 2, -1, 1'b0, 32'h0);
         else
            access(1'b0, lf3[$urandom_range(4, 0)], ra, 32'h0, 0, 2, -1, 1'b0, 32'h0);
      end

      @(negedge clk);
      MemReadM = 1'b0; MemWriteM = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
